// File: rtl/next_pc_logic.sv
// Next-PC selector: chooses PC+INCR or the PC-relative branch target, and
// keeps a registered copy of the chosen address for the datapath and debug.
module next_pc_logic #(
    parameter int                WIDTH    = 64,
    parameter int                INCR     = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] CurrentPC,
    input  logic [WIDTH-1:0] SignExtImm64,
    input  logic             Branch,
    input  logic             ALUZero,
    input  logic             Uncondbranch,
    output logic [WIDTH-1:0] NextPC,
    output logic             BranchTaken,
    output logic             Misaligned,
    output logic [WIDTH-1:0] PCReg
);

    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

    logic             takenSel;
    logic [WIDTH-1:0] seqTarget;
    logic [WIDTH-1:0] branchTarget;

    // Offset arrives already in bytes; both sums wrap modulo 2^WIDTH.
    always_comb begin
        takenSel     = Uncondbranch | (Branch & ALUZero);
        seqTarget    = CurrentPC + INCR_W;
        branchTarget = CurrentPC + SignExtImm64;
    end

    always_comb begin
        NextPC      = takenSel ? branchTarget : seqTarget;
        BranchTaken = takenSel;
        Misaligned  = |NextPC[1:0];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            PCReg <= RESET_PC;
        end else begin
            PCReg <= NextPC;
        end
    end

endmodule

// File: tb/tb_next_pc_logic.sv
// Randomized self-checking bench for next_pc_logic against a behavioural
// model of the branch rules and a queue of expected register values.
module tb_next_pc_logic;

    localparam int          W        = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic          clk;
    logic          rst;
    logic [W-1:0]  cur_pc;
    logic [W-1:0]  imm;
    logic          br;
    logic          zero;
    logic          unc;
    logic [W-1:0]  next_pc;
    logic          taken;
    logic          misaligned;
    logic [W-1:0]  pc_reg;

    logic [W-1:0]  exp_q[$];
    int            num_checks = 0;
    int            num_fails  = 0;

    next_pc_logic #(
        .WIDTH   (W),
        .INCR    (4),
        .RESET_PC(RESET_PC)
    ) dut (
        .CLK         (clk),
        .Reset       (rst),
        .CurrentPC   (cur_pc),
        .SignExtImm64(imm),
        .Branch      (br),
        .ALUZero     (zero),
        .Uncondbranch(unc),
        .NextPC      (next_pc),
        .BranchTaken (taken),
        .Misaligned  (misaligned),
        .PCReg       (pc_reg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // checking task
    task automatic check_value(input string tag, input logic [W-1:0] obs,
                               input logic [W-1:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // behavioural reference: plain 65-bit arithmetic, then modulo 2^64
    function automatic logic [W-1:0] model_next(input logic [W-1:0] pc,
                                                 input logic [W-1:0] off,
                                                 input bit b, input bit z,
                                                 input bit u);
        logic [W:0] sum;
        bit         tk;
        tk  = u || (b && z);
        sum = tk ? ({1'b0, pc} + {1'b0, off}) : ({1'b0, pc} + 65'd4);
        return sum[W-1:0];
    endfunction

    // driver: apply one vector, check combinational outputs, then the register
    task automatic apply(input logic [W-1:0] pc, input logic [W-1:0] off,
                         input bit b, input bit z, input bit u, input bit r,
                         input bit check_reg);
        logic [W-1:0] exp_next;
        bit           exp_taken;
        rst    = r;
        cur_pc = pc;
        imm    = off;
        br     = b;
        zero   = z;
        unc    = u;
        #2;
        exp_next  = model_next(pc, off, b, z, u);
        exp_taken = u || (b && z);
        check_value("next_pc",    next_pc, exp_next);
        check_value("taken",      W'(taken), W'(exp_taken));
        check_value("misaligned", W'(misaligned), W'((exp_next % 4) != 0));
        exp_q.push_back(r ? RESET_PC : exp_next);
        @(posedge clk);
        #1;
        if (check_reg) begin
            check_value("pc_reg", pc_reg, exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [W-1:0] rpc;
        logic [W-1:0] roff;
        rst = 1'b1; cur_pc = '0; imm = '0; br = 1'b0; zero = 1'b0; unc = 1'b0;
        @(negedge clk);

        // directed vectors
        apply(64'd0, 64'd4, 0, 0, 0, 1, 1);                 // reset, PC+4
        apply(64'd0, 64'd16, 0, 1, 1, 0, 1);                // uncond taken
        apply(64'd100, 64'd40, 1, 1, 0, 0, 1);              // cbz taken
        apply(64'd100, 64'd40, 1, 0, 0, 0, 1);              // cbz not taken
        apply(64'd100, 64'd40, 0, 1, 0, 0, 1);              // zero alone
        apply(64'd100, 64'd40, 1, 1, 1, 0, 1);              // both branches
        apply(64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 0, 0, 0, 0, 1); // wrap to 0
        apply(64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 0, 1);
        apply(64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1, 0, 1);
        apply(64'd0, 64'd6, 0, 0, 1, 0, 1);                 // misaligned
        apply(64'd8, 64'd0, 0, 0, 0, 1, 1);                 // reset again
        apply(64'd8, 64'd0, 0, 0, 0, 0, 1);                 // PCReg = 12
        apply(64'd200, 64'd64, 0, 0, 1, 1, 1);              // reset mid-run

        // randomized vectors
        for (int i = 0; i < 300; i++) begin
            rpc  = {$urandom, $urandom};
            roff = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc  = rpc & 64'hFFFF_FFFF_FFFF_FFFC;
            if ($urandom_range(0, 5) == 0) rpc  = 64'hFFFF_FFFF_FFFF_FFF0 | rpc[3:0];
            if ($urandom_range(0, 3) == 0) roff = {{48{roff[15]}}, roff[15:0]};
            apply(rpc, roff, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1);
        end

        check_value("queue_empty", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/next_pc_logic.md
Name: next_pc_logic

Overview:
- Next-program-counter selector for the single-cycle processor datapath.
- Computes the address of the next instruction from the current PC, the sign-extended branch offset and the branch control signals:
  - sequential PC+4, or
  - PC-relative branch target.
- Also provides a registered PC copy, a branch-taken flag and a misalignment flag for the surrounding datapath and debug.

Parameters:
- WIDTH, 64, address/data width in bits.
- INCR, 4, sequential instruction increment in bytes.
- RESET_PC, 0, value loaded into PCReg on reset.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- CurrentPC  input  WIDTH  address of the instruction currently executing.
- SignExtImm64  input  WIDTH  sign-extended branch offset, already in bytes (no shift applied here).
- Branch  input  1  conditional-branch (CBZ-type) instruction decoded.
- ALUZero  input  1  ALU zero flag for the current instruction.
- Uncondbranch  input  1  unconditional branch (B-type) decoded.
- NextPC  output  WIDTH  combinational next instruction address.
- BranchTaken  output  1  combinational; 1 when the branch target is selected.
- Misaligned  output  1  combinational; 1 when NextPC[1:0] != 0.
- PCReg  output  WIDTH  registered copy of NextPC.

Behaviour:
- Taken = Uncondbranch | (Branch & ALUZero).
- NextPC selection:
  - Taken = 1: NextPC = CurrentPC + SignExtImm64.
  - Taken = 0: NextPC = CurrentPC + INCR.
- Offset handling:
  - The offset is added as-is: no left shift and no re-extension inside the block.
- Arithmetic:
  - Unsigned WIDTH-bit addition, modulo 2^WIDTH.
  - Carry-out is discarded; wrap-around is silent.
  - Negative offsets work through two's complement (e.g. PC 0x10 + 0xFFFF...FFF0 = 0).
- Branch gating:
  - Branch=1 with ALUZero=0 is not taken: NextPC = PC+4.
  - ALUZero alone, with both Branch and Uncondbranch low, has no effect.
  - Uncondbranch=1 takes the branch regardless of Branch and ALUZero.
  - Branch and Uncondbranch both high counts as taken.
- NextPC, BranchTaken and Misaligned are purely combinational:
  - Zero cycle latency.
  - Valid within one propagation delay of any input change.
  - Independent of CLK and Reset.
- PCReg:
  - On each rising CLK edge, Reset=1 → RESET_PC; otherwise PCReg <= NextPC.
  - Reset is synchronous; asserting Reset mid-operation affects PCReg only at the next edge and never affects NextPC.
  - Before the first edge with Reset high, PCReg is undefined.
- Misaligned is informational only; it does not alter NextPC.
- No X-masking: X on control inputs may propagate to the outputs.

Test Plan:
- CurrentPC=0, SignExtImm64=4, Branch=0, ALUZero=0, Uncondbranch=0 → NextPC=4, BranchTaken=0, Misaligned=0.
- CurrentPC=0, SignExtImm64=16, Branch=0, ALUZero=1, Uncondbranch=1 → NextPC=16, BranchTaken=1.
- CurrentPC=100, imm=40, Branch=1:
  - ALUZero=1 → NextPC=140.
  - ALUZero=0 → NextPC=104.
- Wrap and negative offset:
  - CurrentPC=0xFFFFFFFFFFFFFFFC, no branch → NextPC=0.
  - CurrentPC=0x20, imm=0xFFFFFFFFFFFFFFF0, Uncondbranch=1 → NextPC=0x10.
- Register:
  - Reset=1 for one CLK edge → PCReg=0.
  - Release Reset with CurrentPC=8, no branch; next edge → PCReg=12.
  - Assert Reset mid-run → PCReg=0 at the following edge while NextPC is unchanged.
- Misaligned: CurrentPC=0, imm=6, Uncondbranch=1 → NextPC=6, Misaligned=1.
